// File: rtl/squares_pkg.sv
// squares_pkg: shared widths and square constant table for the 3-bit squarer
package squares_pkg;
  localparam int IN_W  = 3;
  localparam int OUT_W = 2 * IN_W;
  localparam logic [OUT_W-1:0] SQ_TABLE [2**IN_W] = '{
    6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49
  };
endpackage

// File: rtl/square_lut_3b.sv
// square_lut_3b: combinational 3-bit operand to 6-bit square lookup
module square_lut_3b
  import squares_pkg::*;
(
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] sq
);
  assign sq = SQ_TABLE[in];
endmodule

// File: rtl/squares_3bit.sv
// squares_3bit: registered unsigned squarer with one-cycle latency and valid strobe
module squares_3bit
  import squares_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  output logic [OUT_W-1:0] out
);
  logic [OUT_W-1:0] sq;
  square_lut_3b u_lut (.in(in), .sq(sq));
  // out keeps its last value when idle; only out_valid tracks in_valid
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= sq;
    end
endmodule

// File: tb/tb_squares_3bit.sv
// tb_squares_3bit: directed self-checking bench for squares_3bit
module tb_squares_3bit;
  import squares_pkg::*;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in = '0;
  logic             out_valid;
  logic [OUT_W-1:0] out;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [5:0] exp_sq [8] = '{6'b000000, 6'b000001, 6'b000100, 6'b001001,
                             6'b010000, 6'b011001, 6'b100100, 6'b110001};

  squares_3bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
    .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [2:0] i);
    @(negedge clk);
    in_valid = v;
    in = i;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [5:0] e);
    total_cnt++;
    if (out !== e) $display("FAIL %s: out=%b expected=%b", name, out, e);
    else pass_cnt++;
  endtask

  task automatic chk_valid(input string name, input logic e);
    total_cnt++;
    if (out_valid !== e) $display("FAIL %s: out_valid=%b expected=%b", name, out_valid, e);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    #1;
    chk_out("reset_initial_out", 6'b000000);
    chk_valid("reset_initial_valid", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'd7);
    chk_out("reset_pre_capture", 6'b110001);
    chk_valid("reset_pre_valid", 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("reset_async_out", 6'b000000);
    chk_valid("reset_async_valid", 1'b0);
    @(posedge clk);
    #1;
    chk_out("reset_held_out", 6'b000000);
    chk_valid("reset_held_valid", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    step(1'b0, 3'd7);
    chk_out("reset_release_idle_out", 6'b000000);
    chk_valid("reset_release_idle_valid", 1'b0);
    step(1'b1, 3'd3);
    chk_out("reset_first_capture", 6'b001001);
    chk_valid("reset_first_valid", 1'b1);
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i));
      chk_out($sformatf("sweep_%0d", i), exp_sq[i]);
      chk_valid($sformatf("sweep_valid_%0d", i), 1'b1);
      total_cnt++;
      if (out[1] !== 1'b0) $display("FAIL inv_bit1_%0d: out[1]=%b expected=0", i, out[1]);
      else pass_cnt++;
      total_cnt++;
      if (out[0] !== 1'(i)) $display("FAIL inv_bit0_%0d: out[0]=%b expected=%b", i, out[0], 1'(i));
      else pass_cnt++;
      total_cnt++;
      if (int'(out) !== i * i) $display("FAIL inv_square_%0d: out=%0d expected=%0d", i, out, i * i);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold;
    step(1'b1, 3'd5);
    chk_out("hold_capture", 6'b011001);
    chk_valid("hold_capture_valid", 1'b1);
    step(1'b0, 3'd7);
    chk_out("hold_out_1", 6'b011001);
    chk_valid("hold_valid_1", 1'b0);
    step(1'b0, 3'd7);
    chk_out("hold_out_2", 6'b011001);
    chk_valid("hold_valid_2", 1'b0);
  endtask

  task automatic test_boundary;
    step(1'b1, 3'd7);
    chk_out("boundary_max", 6'b110001);
    chk_valid("boundary_max_valid", 1'b1);
    @(negedge clk);
    in = 3'd0;
    chk_valid("boundary_mid_valid", 1'b1);
    @(posedge clk);
    #1;
    chk_out("boundary_zero", 6'b000000);
    chk_valid("boundary_zero_valid", 1'b1);
  endtask

  task automatic test_reset_during_capture;
    @(negedge clk);
    in_valid = 1'b1;
    in = 3'd6;
    #2;
    rst = 1'b1;
    #1;
    chk_out("rdc_async_out", 6'b000000);
    chk_valid("rdc_async_valid", 1'b0);
    @(posedge clk);
    #1;
    chk_out("rdc_edge_out", 6'b000000);
    chk_valid("rdc_edge_valid", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_out("rdc_after_out", 6'b000000);
    chk_valid("rdc_after_valid", 1'b0);
  endtask

  initial begin
    test_reset;
    test_sweep;
    test_hold;
    test_boundary;
    test_reset_during_capture;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
